// File: rtl/reg_bank_wb.sv
// Register bank fed by the write-back selector: two registered read ports with
// write bypass, plus a per-register pending-write scoreboard for hazard detection.
module reg_bank_wb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_WB,
  input  logic                  WE_RB,
  input  logic [ADDR_W-1:0]     A_W,
  input  logic [ADDR_W-1:0]     A_A,
  input  logic [ADDR_W-1:0]     A_B,
  input  logic                  ISSUE,
  input  logic [ADDR_W-1:0]     A_I,
  output logic [DATA_W-1:0]     out_A,
  output logic [DATA_W-1:0]     out_B,
  output logic                  HAZ,
  output logic [(1<<ADDR_W)-1:0] PEND
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [NREGS-1:0]  pend_q, pend_d;

  logic wr_ok;
  logic byp_a, byp_b;
  logic raw_a, raw_b;

  // A write to r0 is dropped entirely, so it can neither land nor bypass.
  assign wr_ok = WE_RB & ~(ZERO_R0 && (A_W == '0));
  assign byp_a = wr_ok & (A_W == A_A);
  assign byp_b = wr_ok & (A_W == A_B);

  always_comb begin
    out_a_d = regs_q[A_A];
    if (ZERO_R0 && (A_A == '0)) out_a_d = '0;
    else if (byp_a)             out_a_d = in_WB;

    out_b_d = regs_q[A_B];
    if (ZERO_R0 && (A_B == '0)) out_b_d = '0;
    else if (byp_b)             out_b_d = in_WB;
  end

  // A new issue in the same cycle as a write-back wins: the newer producer is still outstanding.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (WE_RB && (A_W == ADDR_W'(i)))
        pend_d[i] = 1'b0;
      if (ISSUE && (A_I == ADDR_W'(i)) && !(ZERO_R0 && (i == 0)))
        pend_d[i] = 1'b1;
    end
  end

  // A write arriving this cycle resolves the hazard because the read bypasses it.
  assign raw_a = pend_q[A_A] & ~(WE_RB & (A_W == A_A));
  assign raw_b = pend_q[A_B] & ~(WE_RB & (A_W == A_B));
  assign HAZ   = raw_a | raw_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      pend_q  <= '0;
    end else begin
      if (wr_ok) regs_q[A_W] <= in_WB;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      pend_q  <= pend_d;
    end
  end

  assign out_A = out_a_q;
  assign out_B = out_b_q;
  assign PEND  = pend_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: reset, write/read, bypass, r0, scoreboard and collision cases.
module tb_reg_bank_wb;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_WB;
  logic        WE_RB;
  logic [3:0]  A_W, A_A, A_B, A_I;
  logic        ISSUE;
  logic [31:0] out_A, out_B;
  logic        HAZ;
  logic [15:0] PEND;

  int checks = 0;
  int errors = 0;

  reg_bank_wb #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_WB(in_WB), .WE_RB(WE_RB), .A_W(A_W),
    .A_A(A_A), .A_B(A_B), .ISSUE(ISSUE), .A_I(A_I),
    .out_A(out_A), .out_B(out_B), .HAZ(HAZ), .PEND(PEND)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE_RB = 1'b0; ISSUE = 1'b0; in_WB = '0;
    A_W = '0; A_A = '0; A_B = '0; A_I = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL reset_out_A got %h exp %h", out_A, 32'h0); end
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL reset_out_B got %h exp %h", out_B, 32'h0); end
    checks++; if (PEND !== 16'h0) begin errors++; $display("FAIL reset_PEND got %h exp %h", PEND, 16'h0); end
    checks++; if (HAZ !== 1'b0) begin errors++; $display("FAIL reset_HAZ got %b exp 0", HAZ); end
    rst_n = 1'b1;
    // Load some state, then reset in the middle of a cycle with a write in flight.
    WE_RB = 1'b1; A_W = 4'd2; in_WB = 32'h1234; A_A = 4'd2; A_B = 4'd2;
    ISSUE = 1'b1; A_I = 4'd7;
    step();
    checks++; if (out_A !== 32'h1234) begin errors++; $display("FAIL pre_reset_out_A got %h exp %h", out_A, 32'h1234); end
    checks++; if (PEND !== 16'h0080) begin errors++; $display("FAIL pre_reset_PEND got %h exp %h", PEND, 16'h0080); end
    ISSUE = 1'b0; A_A = 4'd7; in_WB = 32'h5555;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL midreset_out_A got %h exp %h", out_A, 32'h0); end
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL midreset_out_B got %h exp %h", out_B, 32'h0); end
    checks++; if (PEND !== 16'h0) begin errors++; $display("FAIL midreset_PEND got %h exp %h", PEND, 16'h0); end
    checks++; if (HAZ !== 1'b0) begin errors++; $display("FAIL midreset_HAZ got %b exp 0", HAZ); end
    step();
    rst_n = 1'b1;
    WE_RB = 1'b0; A_A = 4'd2; A_B = 4'd2;
    step();
    checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL post_reset_r2 got %h exp %h", out_A, 32'h0); end
  endtask

  task automatic test_write_read();
    idle_inputs();
    WE_RB = 1'b1; A_W = 4'd3; in_WB = 32'hDEAD_BEEF;
    step();
    WE_RB = 1'b0; A_A = 4'd3; A_B = 4'd4;
    step();
    checks++; if (out_A !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_out_A got %h exp %h", out_A, 32'hDEAD_BEEF); end
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL wr_rd_out_B got %h exp %h", out_B, 32'h0); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    WE_RB = 1'b1; A_W = 4'd5; in_WB = 32'd1;
    step();
    in_WB = 32'd7; A_A = 4'd5; A_B = 4'd5;
    step();
    checks++; if (out_A !== 32'd7) begin errors++; $display("FAIL bypass_out_A got %h exp %h", out_A, 32'd7); end
    checks++; if (out_B !== 32'd7) begin errors++; $display("FAIL bypass_out_B got %h exp %h", out_B, 32'd7); end
    WE_RB = 1'b0; A_B = 4'd3;
    step();
    checks++; if (out_A !== 32'd7) begin errors++; $display("FAIL bypass_stored got %h exp %h", out_A, 32'd7); end
    checks++; if (out_B !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_portB_r3 got %h exp %h", out_B, 32'hDEAD_BEEF); end
  endtask

  task automatic test_r0();
    idle_inputs();
    WE_RB = 1'b1; A_W = 4'd0; in_WB = 32'hFFFF_FFFF; A_A = 4'd0; A_B = 4'd0;
    ISSUE = 1'b1; A_I = 4'd0;
    #1;
    checks++; if (HAZ !== 1'b0) begin errors++; $display("FAIL r0_HAZ got %b exp 0", HAZ); end
    step();
    checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL r0_bypass_A got %h exp %h", out_A, 32'h0); end
    checks++; if (PEND !== 16'h0) begin errors++; $display("FAIL r0_PEND got %h exp %h", PEND, 16'h0); end
    WE_RB = 1'b0; ISSUE = 1'b0;
    step();
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL r0_read_B got %h exp %h", out_B, 32'h0); end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    ISSUE = 1'b1; A_I = 4'd6; A_A = 4'd1; A_B = 4'd1;
    step();
    checks++; if (PEND !== 16'h0040) begin errors++; $display("FAIL sb_set_PEND got %h exp %h", PEND, 16'h0040); end
    ISSUE = 1'b0; A_A = 4'd6;
    #1;
    checks++; if (HAZ !== 1'b1) begin errors++; $display("FAIL sb_haz_A got %b exp 1", HAZ); end
    A_A = 4'd1; A_B = 4'd6;
    #1;
    checks++; if (HAZ !== 1'b1) begin errors++; $display("FAIL sb_haz_B got %b exp 1", HAZ); end
    A_B = 4'd1;
    #1;
    checks++; if (HAZ !== 1'b0) begin errors++; $display("FAIL sb_no_haz got %b exp 0", HAZ); end
    WE_RB = 1'b1; A_W = 4'd6; in_WB = 32'h66; A_A = 4'd6; A_B = 4'd6;
    #1;
    checks++; if (HAZ !== 1'b0) begin errors++; $display("FAIL sb_bypass_haz got %b exp 0", HAZ); end
    step();
    checks++; if (PEND !== 16'h0) begin errors++; $display("FAIL sb_clear_PEND got %h exp %h", PEND, 16'h0); end
    checks++; if (out_A !== 32'h66) begin errors++; $display("FAIL sb_out_A got %h exp %h", out_A, 32'h66); end
    WE_RB = 1'b0;
    #1;
    checks++; if (HAZ !== 1'b0) begin errors++; $display("FAIL sb_after_haz got %b exp 0", HAZ); end
  endtask

  task automatic test_collision();
    idle_inputs();
    ISSUE = 1'b1; A_I = 4'd9;
    step();
    checks++; if (PEND !== 16'h0200) begin errors++; $display("FAIL col_pre_PEND got %h exp %h", PEND, 16'h0200); end
    WE_RB = 1'b1; A_W = 4'd9; in_WB = 32'd4;
    step();
    checks++; if (PEND !== 16'h0200) begin errors++; $display("FAIL col_PEND got %h exp %h", PEND, 16'h0200); end
    ISSUE = 1'b0; WE_RB = 1'b0; A_A = 4'd9;
    #1;
    checks++; if (HAZ !== 1'b1) begin errors++; $display("FAIL col_HAZ got %b exp 1", HAZ); end
    step();
    checks++; if (out_A !== 32'd4) begin errors++; $display("FAIL col_reg9 got %h exp %h", out_A, 32'd4); end
    WE_RB = 1'b1; A_W = 4'd9; in_WB = 32'd8;
    step();
    checks++; if (PEND !== 16'h0) begin errors++; $display("FAIL col_clear got %h exp %h", PEND, 16'h0); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    ISSUE = 1'b1; A_I = 4'd12;
    step();
    ISSUE = 1'b1; A_I = 4'd12;
    WE_RB = 1'b1; A_W = 4'd10; in_WB = 32'hA0;
    step();
    checks++; if (PEND !== 16'h1000) begin errors++; $display("FAIL b2b_nonpend_PEND got %h exp %h", PEND, 16'h1000); end
    ISSUE = 1'b0; A_W = 4'd11; in_WB = 32'hB0; A_A = 4'd10; A_B = 4'd12;
    #1;
    checks++; if (HAZ !== 1'b1) begin errors++; $display("FAIL b2b_HAZ got %b exp 1", HAZ); end
    step();
    checks++; if (out_A !== 32'hA0) begin errors++; $display("FAIL b2b_r10 got %h exp %h", out_A, 32'hA0); end
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL b2b_r12 got %h exp %h", out_B, 32'h0); end
    A_W = 4'd12; in_WB = 32'hC0; A_A = 4'd11; A_B = 4'd12;
    step();
    checks++; if (out_A !== 32'hB0) begin errors++; $display("FAIL b2b_r11 got %h exp %h", out_A, 32'hB0); end
    checks++; if (out_B !== 32'hC0) begin errors++; $display("FAIL b2b_r12_byp got %h exp %h", out_B, 32'hC0); end
    checks++; if (PEND !== 16'h0) begin errors++; $display("FAIL b2b_PEND got %h exp %h", PEND, 16'h0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
